// File: rtl/mult_ctrl.sv
// mult_ctrl: sequencing controller for the 32-bit shift-add multiplier.
// Drives datapath mux selects, counts N_ITER shift-add iterations and
// reports busy/done. Optional feature macro: MULT_CTRL_ABORT_EN (adds the
// abort input, which cancels an operation in LOAD or CALC).
module mult_ctrl #(
  parameter int unsigned N_ITER = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic b_lsb,
`ifdef MULT_CTRL_ABORT_EN
  input  logic abort,
`endif
  output logic a_sel,
  output logic b_sel,
  output logic prod_sel,
  output logic add_sel,
  output logic busy,
  output logic done
);

  localparam int unsigned CW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N_ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          abort_req;

`ifdef MULT_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // State and iteration counter registers; reset returns to IDLE at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter update and datapath select decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sel    = 1'b1;
    b_sel    = 1'b1;
    prod_sel = 1'b1;
    add_sel  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // start has priority over abort here because abort is not decoded in IDLE
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        a_sel    = 1'b0;
        b_sel    = 1'b0;
        prod_sel = 1'b0;
        busy     = 1'b1;
        cnt_d    = '0;
        state_d  = abort_req ? S_IDLE : S_CALC;
      end
      S_CALC: begin
        busy    = 1'b1;
        add_sel = b_lsb;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_DONE;
        if (abort_req) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: doc/mult_ctrl.md
# mult_ctrl

Sequencing controller for the 32-bit shift-add multiplier datapath. It accepts a start request and drives the datapath mux selects `a_sel`, `b_sel`, `prod_sel` and `add_sel`. It reads `b_lsb` back from the datapath and reports `busy` and `done` to the requester. It sits beside the datapath in the multiplier top level and shares that level's clock and reset.

## Interface
- `N_ITER`, default 32: number of shift-add iterations; equals operand width.
- `clk`  in  1  rising-edge clock, shared with the datapath.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `b_lsb`  in  1  LSB of the datapath B register.
- `a_sel`  out  1  0 = load operand `a`; 1 = shift A left.
- `b_sel`  out  1  0 = load operand `b`; 1 = shift B right.
- `prod_sel`  out  1  0 = clear product; 1 = take add_sel mux output.
- `add_sel`  out  1  0 = hold product; 1 = product + A.
- `busy`  out  1  high in LOAD and CALC.
- `done`  out  1  one-cycle pulse in DONE; product valid.
- `abort`  in  1  only with `MULT_CTRL_ABORT_EN`; see Configuration.

## Operation
- Four states: IDLE, LOAD, CALC, DONE. Iteration counter `cnt` is $clog2(N_ITER) bits wide.
- IDLE
  - Outputs: `a_sel=1`, `b_sel=1`, `prod_sel=1`, `add_sel=0`.
  - The product is held; A and B shift harmlessly.
  - `start=1` moves to LOAD.
- LOAD
  - Outputs: `a_sel=0`, `b_sel=0`, `prod_sel=0`, `add_sel=0`.
  - The edge loads `a` and `b` and clears the product.
  - `cnt` is set to 0. Unconditional move to CALC.
- CALC
  - Outputs: `a_sel=1`, `b_sel=1`, `prod_sel=1`.
  - `add_sel = b_lsb`. This is combinational (Mealy) from the current B register value.
  - `cnt` increments each cycle. When `cnt == N_ITER-1`, move to DONE; otherwise stay.
- DONE
  - Outputs: the IDLE select values, plus `done=1`.
  - Unconditional move to IDLE.
  - `start` is ignored in DONE.
- `start` is ignored in LOAD, CALC and DONE. No queuing.
- `busy` and `done` are never high together.
- Product width is not the controller's concern. The datapath A register is 32 bits, so `a<<i` loses bits above 31. The controller always runs exactly N_ITER iterations regardless of operand values.

## Timing
- Start-to-result latency:
  - `start` sampled high in IDLE at edge T: LOAD during cycle T+1, CALC during cycles T+2..T+N_ITER+1.
  - DONE during cycle T+N_ITER+2, which is 34 cycles for N_ITER=32.
  - `prod` is valid in the DONE cycle and held afterwards until the next LOAD edge.
- Back-to-back operations:
  - With `start` held high, the cycle after DONE is IDLE, and `start` is sampled there.
  - The period is N_ITER+3 = 35 cycles.
- Reset values (async assertion takes effect immediately):
  - State IDLE, `cnt=0`, `busy=0`, `done=0`.
  - `a_sel=1`, `b_sel=1`, `prod_sel=1`, `add_sel=0`.
- Reset mid-operation: return to IDLE with no `done` pulse. The datapath registers are cleared by the same reset.
- Deassertion of `reset` is assumed synchronous to `clk`, as handled by the top-level reset synchronizer.

## Configuration
- `MULT_CTRL_ABORT_EN` defined:
  - Port `abort` exists.
  - `abort=1` in LOAD or CALC moves to IDLE at the next edge, with no `done` pulse and `cnt` cleared.
  - `abort` is ignored in IDLE and DONE.
  - If `abort` and `start` are both high in IDLE, `start` wins.
- `MULT_CTRL_ABORT_EN` undefined: no `abort` port; every operation runs to DONE.

## Test plan
- Reset, then idle 5 cycles:
  - all outputs hold their reset values;
  - `busy=0`, `done=0`.
- Integrated test, a=3, b=5, `start` pulsed one cycle:
  - `busy` high for 33 cycles;
  - `done` pulses exactly 34 cycles after the start edge;
  - `prod=15`, held afterwards.
- Integrated test, a=0x0000FFFF, b=0x0000FFFF:
  - `prod=0xFFFE0001` at `done`;
  - a second run with a=0x12345678, b=0 gives `prod=0`.
- Standalone controller with modelled `b_lsb` pattern 1,0,1,1,0…:
  - in CALC, `add_sel` equals `b_lsb` in the same cycle;
  - in IDLE and DONE, `add_sel=0`.
- `start` held high for 100 cycles:
  - `done` pulses every 35 cycles;
  - `start` pulses during CALC do not restart or extend the operation.
- `reset` asserted in CALC cycle 10:
  - immediately IDLE with the reset output values and no `done`;
  - with `MULT_CTRL_ABORT_EN`, `abort` at CALC cycle 10 gives IDLE the next cycle and no `done`.
